// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   - op codes seen on the op port (also used by the core's controller)
//   - FSM state encoding
//   - step mode selector for the iteration sub-module
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Ports:
//   mode     : MODE_MUL (shift-add) or MODE_DIV (restoring shift-subtract)
//   acc      : 2*WIDTH-bit accumulator {upper, lower}
//   operand  : multiplicand (MUL) or divisor magnitude (DIV)
//   cnt      : iterations remaining; zero means hold the accumulator
//   acc_next : accumulator after this iteration (DIV leaves LSB clear)
//   qbit     : quotient bit produced by a DIV iteration
module muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  mode_t              mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted_rem;
  logic             rem_ge;
  logic [WIDTH-1:0] diff;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set; the carry shifts back in on the right shift.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};

  // Divide: remainder shifted left with the next dividend bit pulled in.
  // The WIDTH+1-bit compare decides the quotient bit; when it succeeds the
  // difference always fits in WIDTH bits.
  assign shifted_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_ge      = shifted_rem >= {1'b0, operand};
  assign diff        = shifted_rem[WIDTH-1:0] - operand;

  always_comb begin
    acc_next = acc;
    qbit     = 1'b0;
    if (cnt != '0) begin
      if (mode == MODE_MUL) begin
        if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
        else        acc_next = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
      end else begin
        qbit     = rem_ge;
        acc_next = {(rem_ge ? diff : shifted_rem[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start, op  : request and op code; accepted only while busy==0
//   srca, srcb : rs / rt operands
//   busy       : operation in flight (WIDTH+1 cycles after accept)
//   done       : one-cycle pulse in the cycle hi/lo take the new result
//   hi, lo     : HI / LO registers
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   operand;
  logic               is_div, neg_q, neg_r, div0;
  logic               qbit;
  logic               op_signed;
  mode_t              mode;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // MULT and DIV (op[0]==0) are the signed variants.
  assign op_signed = ~op[0];
  assign mode      = (state == DIV) ? MODE_DIV : MODE_MUL;

  muldiv_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (operand),
    .cnt      (cnt),
    .acc_next (acc_step),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !op[2]) state_nxt = op[1] ? DIV : MUL;
      MUL,
      DIV:  if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              // Magnitudes only; MIN_INT maps onto itself, read as unsigned.
              acc     <= {{WIDTH{1'b0}}, cond_neg(srca, op_signed && srca[WIDTH-1])};
              operand <= cond_neg(srcb, op_signed && srcb[WIDTH-1]);
              cnt     <= CNT_W'(WIDTH);
              is_div  <= op[1];
              neg_q   <= op_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
              neg_r   <= op_signed && srca[WIDTH-1];
              div0    <= (srcb == '0);
            end
            OP_MTHI: hi <= srca;
            OP_MTLO: lo <= srca;
            default: ;
          endcase
        end
        MUL, DIV: begin
          // The quotient bit fills the LSB the step module vacated.
          acc <= acc_step | {{(2*WIDTH-1){1'b0}}, qbit};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            // Divide by zero leaves the dividend in the remainder half; the
            // remainder sign fix restores the raw dividend, the quotient is forced.
            lo <= div0 ? {WIDTH{1'b1}} : cond_neg(acc[WIDTH-1:0], neg_q);
            hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
          end else begin
            {hi, lo} <= cond_neg2(acc, neg_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;
  import mips_muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [WIDTH-1:0] srca = '0;
  logic [WIDTH-1:0] srcb = '0;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  int lat, busyc;

  mips_muldiv #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present a request from the falling edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles until done, with busy sampled once per cycle; bounded.
  task automatic wait_done(output int l, output int bc);
    l = 0; bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int l, output int bc);
    issue(o, a, b);
    wait_done(l, bc);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk) reset = 1'b0;

    // 1. MULTU max*max, latency and busy length
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busyc);
    check("t1 latency", lat, 33);
    check("t1 busy cycles", busyc, 33);
    check("t1 busy in done", busy, 0);
    check("t1 hi", hi, 32'hFFFFFFFE);
    check("t1 lo", lo, 32'h00000001);
    @(posedge clk); #1;
    check("t1 done one cycle", done, 0);

    // 2. signed multiply and divide
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, busyc);
    check("t2 mult hi", hi, 32'hFFFFFFFF);
    check("t2 mult lo", lo, 32'hFFFFFFEB);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, busyc);
    check("t2 div lo", lo, 32'hFFFFFFFD);
    check("t2 div hi", hi, 32'hFFFFFFFF);

    // 3. divide by zero and signed overflow
    run_op(OP_DIVU, 32'd7, 32'd0, lat, busyc);
    check("t3 div0 latency", lat, 33);
    check("t3 div0 lo", lo, 32'hFFFFFFFF);
    check("t3 div0 hi", hi, 32'h00000007);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busyc);
    check("t3 ovf lo", lo, 32'h80000000);
    check("t3 ovf hi", hi, 32'h00000000);

    // reserved op is ignored
    issue(3'b110, 32'h11111111, 32'h2);
    check("rsv busy", busy, 0);
    check("rsv hi", hi, 32'h00000000);
    check("rsv lo", lo, 32'h80000000);

    // 4. MTHI / MTLO
    issue(OP_MTHI, 32'h00001234, 32'h0);
    check("t4 mthi hi", hi, 32'h00001234);
    check("t4 mthi lo kept", lo, 32'h80000000);
    check("t4 mthi busy", busy, 0);
    check("t4 mthi done", done, 0);
    issue(OP_MTLO, 32'h0000ABCD, 32'h0);
    check("t4 mtlo lo", lo, 32'h0000ABCD);
    check("t4 mtlo hi kept", hi, 32'h00001234);
    check("t4 mtlo done", done, 0);
    @(posedge clk); #1;
    check("t4 done later", done, 0);

    // 5. start while busy is ignored; start in the done cycle is accepted
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    check("t5 busy mid", busy, 1);
    check("t5 hi held", hi, 32'h00001234);
    check("t5 lo held", lo, 32'h0000ABCD);
    wait_done(lat, busyc);
    check("t5 remaining latency", lat, 23);
    check("t5 lo", lo, 32'h1E);
    check("t5 hi", hi, 32'h0);
    run_op(OP_DIVU, 32'd100, 32'd7, lat, busyc);
    check("t5 b2b latency", lat, 33);
    check("t5 b2b lo", lo, 32'hE);
    check("t5 b2b hi", hi, 32'h2);

    // 6. reset mid-operation
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6 busy after reset", busy, 0);
    check("t6 hi after reset", hi, 0);
    check("t6 lo after reset", lo, 0);
    check("t6 done after reset", done, 0);
    @(negedge clk) reset = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, busyc);
    check("t6 latency", lat, 33);
    check("t6 lo", lo, 32'hE);
    check("t6 hi", hi, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
